// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and types
// for the clock-enable timebase.
package tick_gen_pkg;

   localparam int REF_HZ    = 1_000_000;
   localparam int BASE_HZ   = 1_000;
   localparam int CNT_W_DEF = 24;
   localparam int NCH_DEF   = 3;
   localparam int PRE_DEF   = REF_HZ / BASE_HZ;

   localparam logic [NCH_DEF*CNT_W_DEF-1:0] DIV_DEF =
      {24'd500, 24'd2, 24'd1};
   localparam logic [NCH_DEF-1:0] CASC_DEF = 3'b110;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] div;
      logic                 casc;
   } div_cfg_t;

   function automatic div_cfg_t mk_cfg(
      input logic [CNT_W_DEF-1:0] div,
      input logic                 casc
   );
      div_cfg_t c;
      c.div  = div;
      c.casc = casc;
      return c;
   endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: one divider stage with active/shadow
// divisor, pending flag, tick and square output.
module tick_div
   import tick_gen_pkg::*;
#(
   parameter div_cfg_t DEF = '0
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en_i,
   input  logic     sync_i,
   input  logic     src_i,
   input  logic     we_i,
   input  div_cfg_t cfg_i,
   output logic     tick_o,
   output logic     sq_o,
   output logic     casc_o,
   output logic     pend_o
);

   localparam logic [CNT_W_DEF-1:0] ONE = CNT_W_DEF'(1);

   logic [CNT_W_DEF-1:0] cnt_q, cnt_d;
   div_cfg_t             act_q, act_d;
   div_cfg_t             shd_q, shd_d;
   logic                 pend_q, pend_d;
   logic                 tick_q, tick_d;
   logic                 sq_q, sq_d;
   logic                 stop, wrap, apply;

   assign stop  = (act_q.div == '0);
   assign wrap  = ~sync_i & en_i & src_i & ~stop &
                  (cnt_q == act_q.div - ONE);
   assign apply = pend_q & (sync_i | wrap | stop);

   // Counter, tick and square-wave next state.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sync_i) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (en_i) begin
         if (stop) begin
            cnt_d = '0;
         end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
         end else if (src_i) begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   // Shadow capture; a pending shadow lands on a
   // period boundary so no period is ever torn.
   always_comb begin
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      if (apply) begin
         act_d  = shd_q;
         pend_d = 1'b0;
      end
      if (we_i) begin
         shd_d  = cfg_i;
         pend_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         act_q  <= DEF;
         shd_q  <= DEF;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;
   assign casc_o = act_q.casc;
   assign pend_o = pend_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: prescaler plus NCH cascadable
// clock-enable channels in a single clock domain.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int                   NCH      = NCH_DEF,
   parameter int                   CNT_W    = CNT_W_DEF,
   parameter int                   DEF_PRE  = PRE_DEF,
   parameter logic [NCH*CNT_W-1:0] DEF_DIV  = DIV_DEF,
   parameter logic [NCH-1:0]       DEF_CASC = CASC_DEF,
   localparam int                  SEL_W    = $clog2(NCH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             cfg_we_i,
   input  logic [SEL_W-1:0] cfg_sel_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   input  logic             cfg_casc_i,
   output logic             pre_tick_o,
   output logic [NCH-1:0]   tick_o,
   output logic [NCH-1:0]   sq_o,
   output logic [NCH:0]     pend_o
);

   logic           pre_tick;
   logic           pre_we;
   logic           pre_pend;
   logic           unused_pre_sq;
   logic           unused_pre_casc;
   logic           unused_c0;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] casc;
   logic [NCH-1:0] src;
   logic [NCH-1:0] we_ch;
   logic [NCH-1:0] pend_ch;

   assign pre_we = cfg_we_i & (cfg_sel_i == '0);

   tick_div #(
      .DEF(mk_cfg(CNT_W_DEF'(DEF_PRE), 1'b0))
   ) u_pre (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i),
      .sync_i (sync_i),
      .src_i  (1'b1),
      .we_i   (pre_we),
      .cfg_i  (mk_cfg(CNT_W_DEF'(cfg_div_i), 1'b0)),
      .tick_o (pre_tick),
      .sq_o   (unused_pre_sq),
      .casc_o (unused_pre_casc),
      .pend_o (pre_pend)
   );

   // Channel 0 never cascades; its select is forced off.
   assign unused_c0 = casc[0];

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam logic [SEL_W-1:0] SEL = SEL_W'(i + 1);
      localparam logic CASC0 = (i > 0) ? DEF_CASC[i] : 1'b0;
      localparam logic CW    = (i > 0);

      assign we_ch[i] = cfg_we_i & (cfg_sel_i == SEL);

      if (i == 0) begin : g_src0
         assign src[i] = pre_tick;
      end else begin : g_srcn
         assign src[i] = casc[i] ? tick[i-1] : pre_tick;
      end

      tick_div #(
         .DEF(mk_cfg(CNT_W_DEF'(DEF_DIV[i*CNT_W +: CNT_W]),
                     CASC0))
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (en_i),
         .sync_i (sync_i),
         .src_i  (src[i]),
         .we_i   (we_ch[i]),
         .cfg_i  (mk_cfg(CNT_W_DEF'(cfg_div_i),
                         cfg_casc_i & CW)),
         .tick_o (tick[i]),
         .sq_o   (sq_o[i]),
         .casc_o (casc[i]),
         .pend_o (pend_ch[i])
      );
   end

   assign pre_tick_o = pre_tick;
   assign tick_o     = tick;
   assign pend_o     = {pend_ch, pre_pend};

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed and random checks of
// tick_gen against a cycle reference model.
module tb_tick_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_i = 1'b0;
   logic        sync_i = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [1:0]  cfg_sel_i = '0;
   logic [23:0] cfg_div_i = '0;
   logic        cfg_casc_i = 1'b0;
   logic        pre_tick_o;
   logic [2:0]  tick_o;
   logic [2:0]  sq_o;
   logic [3:0]  pend_o;

   int checks = 0;
   int failures = 0;
   int ecnt = 0;
   int at, s0, l0;
   logic sq_prev = 1'b0;

   // Model state; unit 0 = prescaler, unit k = channel k-1.
   int m_div[4], m_sdiv[4], m_cnt[4];
   bit m_casc[4], m_scasc[4], m_pend[4], m_tick[4], m_sq[4];
   int hist[4][$];
   int sq2h[$];

   tick_gen #(
      .NCH      (3),
      .CNT_W    (24),
      .DEF_PRE  (4),
      .DEF_DIV  ({24'd3, 24'd2, 24'd1}),
      .DEF_CASC (3'b110)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .sync_i     (sync_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_sel_i  (cfg_sel_i),
      .cfg_div_i  (cfg_div_i),
      .cfg_casc_i (cfg_casc_i),
      .pre_tick_o (pre_tick_o),
      .tick_o     (tick_o),
      .sq_o       (sq_o),
      .pend_o     (pend_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_div   = '{4, 1, 2, 3};
      m_casc  = '{0, 0, 1, 1};
      m_sdiv  = m_div;
      m_scasc = m_casc;
      for (int u = 0; u < 4; u++) begin
         m_cnt[u]  = 0;
         m_pend[u] = 0;
         m_tick[u] = 0;
         m_sq[u]   = 0;
      end
   endtask

   // One edge: every unit sees its source's previous tick.
   task automatic model_edge();
      bit src[4];
      bit nt[4];
      int sel;
      for (int u = 0; u < 4; u++) begin
         if (u == 0) src[u] = 1;
         else if (m_casc[u]) src[u] = m_tick[u-1];
         else src[u] = m_tick[0];
      end
      for (int u = 0; u < 4; u++) begin
         nt[u] = 0;
         if (sync_i) begin
            m_cnt[u] = 0;
            m_sq[u]  = 0;
         end else if (en_i && m_div[u] == 0) begin
            m_cnt[u] = 0;
         end else if (en_i && src[u]) begin
            if (m_cnt[u] + 1 == m_div[u]) begin
               nt[u]    = 1;
               m_cnt[u] = 0;
               m_sq[u]  = !m_sq[u];
            end else begin
               m_cnt[u]++;
            end
         end
         if (m_pend[u] && (sync_i || nt[u] || m_div[u] == 0)) begin
            m_div[u]  = m_sdiv[u];
            m_casc[u] = m_scasc[u];
            m_pend[u] = 0;
         end
      end
      sel = int'(cfg_sel_i);
      if (cfg_we_i && sel <= 3) begin
         m_sdiv[sel]  = int'(cfg_div_i);
         m_scasc[sel] = (sel >= 2) ? cfg_casc_i : 1'b0;
         m_pend[sel]  = 1;
      end
      m_tick = nt;
   endtask

   function automatic logic [10:0] exp_vec();
      return {m_pend[3], m_pend[2], m_pend[1], m_pend[0],
              m_sq[3], m_sq[2], m_sq[1],
              m_tick[3], m_tick[2], m_tick[1], m_tick[0]};
   endfunction

   function automatic int hget(input int u, input int k);
      if (k < hist[u].size()) return hist[u][k];
      return -1;
   endfunction

   function automatic int ldiff(input int u);
      int n;
      n = hist[u].size();
      if (n < 2) return -1;
      return hist[u][n-1] - hist[u][n-2];
   endfunction

   task automatic hclear();
      for (int u = 0; u < 4; u++) hist[u].delete();
      sq2h.delete();
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      ecnt++;
      chk($sformatf("cyc%0d", ecnt),
          {21'd0, pend_o, sq_o, tick_o, pre_tick_o},
          {21'd0, exp_vec()});
      if (pre_tick_o) hist[0].push_back(ecnt);
      for (int k = 0; k < 3; k++)
         if (tick_o[k]) hist[k+1].push_back(ecnt);
      if (sq_o[2] !== sq_prev) sq2h.push_back(ecnt);
      sq_prev = sq_o[2];
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_pre(input int lim, output int t);
      t = -1;
      for (int i = 0; i < lim; i++) begin
         step();
         if (pre_tick_o) begin
            t = ecnt;
            break;
         end
      end
   endtask

   task automatic cfg_write(input int sel, input int dv, input bit cs);
      cfg_sel_i  = 2'(sel);
      cfg_div_i  = 24'(dv);
      cfg_casc_i = cs;
      cfg_we_i   = 1'b1;
      step();
      cfg_we_i   = 1'b0;
   endtask

   initial begin
      en_i = 1'b1;
      #11;
      chk("reset_out", {21'd0, pend_o, sq_o, tick_o, pre_tick_o}, 32'd0);
      model_reset();
      rst_n = 1'b1;

      // Default schedule.
      steps(80);
      chk("pre_first", hget(0, 0), 4);
      chk("pre_second", hget(0, 1), 8);
      chk("t0_first", hget(1, 0), 5);
      chk("t0_second", hget(1, 1), 9);
      chk("t1_first", hget(2, 0), 10);
      chk("t1_second", hget(2, 1), 18);
      chk("t2_first", hget(3, 0), 27);
      chk("t2_second", hget(3, 1), 51);
      chk("sq2_rise", sq2h.size() > 0 ? sq2h[0] : -1, 27);
      chk("sq2_per", sq2h.size() > 2 ? sq2h[2] - sq2h[0] : -1, 48);

      // Reconfigure channel 0 mid-period.
      hclear();
      steps(2);
      cfg_write(1, 2, 1'b0);
      chk("pend1_set", pend_o[1], 1);
      step();
      chk("pend1_hold", pend_o[1], 1);
      step();
      chk("pend1_clr", pend_o[1], 0);
      steps(60);
      chk("t0_new_first", hget(1, 2), 93);
      chk("t0_period8", ldiff(1), 8);
      chk("t1_period16", ldiff(2), 16);

      // Enable gap shifts the schedule by its length.
      wait_pre(10, l0);
      en_i = 1'b0;
      steps(7);
      en_i = 1'b1;
      wait_pre(20, at);
      chk("en_shift", at - l0, 11);

      // Sync restart.
      sync_i = 1'b1;
      step();
      sync_i = 1'b0;
      s0 = ecnt;
      chk("sync_clr", {21'd0, pend_o, sq_o, tick_o, pre_tick_o}, 32'd0);
      wait_pre(10, at);
      chk("sync_pre", at - s0, 4);

      // Prescaler divisor 0 stalls, then divisor 1.
      cfg_write(0, 0, 1'b0);
      chk("pend0_set", pend_o[0], 1);
      steps(8);
      chk("pend0_clr", pend_o[0], 0);
      hclear();
      steps(20);
      chk("pre_stopped", hist[0].size(), 0);
      chk("t0_stopped", hist[1].size(), 0);
      cfg_write(0, 1, 1'b0);
      chk("pend0_div1", pend_o[0], 1);
      step();
      chk("pend0_apply", pend_o[0], 0);
      hclear();
      steps(5);
      chk("pre_every", hist[0].size(), 5);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         en_i       = ($urandom_range(0, 9) != 0);
         sync_i     = ($urandom_range(0, 49) == 0);
         cfg_we_i   = ($urandom_range(0, 15) == 0);
         cfg_sel_i  = 2'($urandom_range(0, 3));
         cfg_div_i  = 24'($urandom_range(0, 5));
         cfg_casc_i = 1'($urandom_range(0, 1));
         step();
      end
      en_i     = 1'b1;
      sync_i   = 1'b0;
      cfg_we_i = 1'b0;
      steps(3);

      // Asynchronous reset mid-operation.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", {21'd0, pend_o, sq_o, tick_o, pre_tick_o}, 32'd0);
      model_reset();
      hclear();
      sq_prev = 1'b0;
      ecnt = 0;
      #3;
      rst_n = 1'b1;
      steps(30);
      chk("rst_pre", hget(0, 0), 4);
      chk("rst_t0", hget(1, 0), 5);
      chk("rst_t1", hget(2, 0), 10);
      chk("rst_t2", hget(3, 0), 27);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
